// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and width helpers.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One bit of headroom above the largest interval length.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        return $clog2(max_int(on_cycles, off_cycles)) + 1;
    endfunction

    function automatic int pending_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable interval down-counter; done is high while the count is zero.
module cycle_timer #(
    parameter int W = 20
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Holds at zero once expired so done stays asserted until the next load.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (count_reg != '0) begin
            count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into ON/OFF intervals on a registered pin.
// Optional event queue enabled by defining PULSE_STRETCH_QUEUE_EN.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int ON_CYCLES   = 524288,
    parameter int OFF_CYCLES  = 524288,
    parameter int QUEUE_DEPTH = 3
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Event,
    output logic Output,
    output logic Busy,
    output logic Dropped
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || QUEUE_DEPTH < 1) begin : g_param_check
        $error("pulse_stretch: ON_CYCLES, OFF_CYCLES and QUEUE_DEPTH must be >= 1");
    end

    state_t        state_reg;
    state_t        state_next;
    logic          output_reg;
    logic          busy_reg;
    logic          dropped_reg;
    logic          drop_next;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_done;
    logic          off_end;
    logic          pending_zero;
    logic          ev_direct;

    assign off_end = (state_reg == OFF) && timer_done;

    // An event starts the next ON directly when nothing is ahead of it:
    // in IDLE, or in the final OFF cycle with an empty queue.
    assign ev_direct = Event && ((state_reg == IDLE) || (off_end && pending_zero));

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam int PW = pending_width(QUEUE_DEPTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(QUEUE_DEPTH);

    logic [PW-1:0] pending_reg;
    logic [PW-1:0] pending_next;
    logic          consume;

    assign consume      = off_end && (pending_reg != '0);
    assign pending_zero = (pending_reg == '0);

    // A consume and a new event in the same cycle cancel, so saturation
    // is judged against the count after the consume.
    always_comb begin
        pending_next = pending_reg;
        drop_next    = 1'b0;
        if (Event && !ev_direct) begin
            if (consume) begin
                pending_next = pending_reg;
            end else if (pending_reg < DEPTH_P) begin
                pending_next = pending_reg + PW'(1);
            end else begin
                drop_next = 1'b1;
            end
        end else if (consume) begin
            pending_next = pending_reg - PW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end
`else
    assign pending_zero = 1'b1;

    always_comb begin
        drop_next = Event && !ev_direct;
    end
`endif

    always_comb begin
        state_next  = state_reg;
        timer_load  = 1'b0;
        timer_value = ON_LOAD;
        case (state_reg)
            IDLE: begin
                if (Event) begin
                    state_next  = ON;
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end
            end
            ON: begin
                if (timer_done) begin
                    state_next  = OFF;
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end
            end
            OFF: begin
                if (timer_done) begin
                    if (!pending_zero || Event) begin
                        state_next  = ON;
                        timer_load  = 1'b1;
                        timer_value = ON_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .load      (timer_load),
        .load_value(timer_value),
        .done      (timer_done)
    );

    // Pin and Busy are decoded from the next state so they change on the
    // same edge as the state register itself.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= IDLE;
            output_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            output_reg  <= (state_next == ON);
            busy_reg    <= (state_next != IDLE);
            dropped_reg <= drop_next;
        end
    end

    assign Output  = output_reg;
    assign Busy    = busy_reg;
    assign Dropped = dropped_reg;

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter ON_CYCLES, default 524288, number of clock cycles Output is held high per accepted event (minimum 1).
REQ-002 Parameter OFF_CYCLES, default 524288, number of clock cycles Output is held low after each high interval (minimum 1).
REQ-003 Parameter QUEUE_DEPTH, default 3, maximum number of pending events held while busy (minimum 1).
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Event  input  1  single-cycle event strobe, synchronous to Clk, no internal synchroniser.
REQ-007 Output  output  1  stretched level for a physical LED/pin, registered.
REQ-008 Busy  output  1  high whenever the state is not IDLE.
REQ-009 Dropped  output  1  one-cycle registered pulse, cycle after a discarded Event.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, ON, OFF.
REQ-011 In IDLE, Event=1 SHALL move to ON; Output high from the next cycle for exactly ON_CYCLES cycles.
REQ-012 After ON_CYCLES cycles in ON, the FSM SHALL enter OFF with Output low for exactly OFF_CYCLES cycles.
REQ-013 At OFF end: pending>0 -> ON next cycle, pending decremented; pending=0 -> IDLE.
REQ-014 Output SHALL equal 1 iff state is ON; it never glitches between intervals.
REQ-015 Interval timing SHALL use one down-counter, width clog2(max(ON_CYCLES,OFF_CYCLES))+1, reloaded on every state entry.
REQ-016 Event in IDLE SHALL never raise Dropped.
REQ-017 Event in the last OFF cycle with pending=0 SHALL produce the same Output timing as Event in IDLE (ON starts next cycle).
REQ-018 Busy SHALL be registered alongside state, same-cycle consistent with Output.

Reset
REQ-019 Rst_n low SHALL immediately force state IDLE, Output 0, Busy 0, Dropped 0, pending 0, timer 0.
REQ-020 Reset mid-interval SHALL abort the interval and discard all pending events; no Output pulse resumes after release.
REQ-021 First Event SHALL be accepted on the first rising edge with Rst_n high.

Configuration
REQ-022 Macro PULSE_STRETCH_QUEUE_EN defined: Event while Busy SHALL increment pending (width clog2(QUEUE_DEPTH+1)); at pending=QUEUE_DEPTH the Event is discarded and Dropped pulses.
REQ-023 Simultaneous Event and consume (REQ-013) with the macro defined SHALL leave pending unchanged; saturation SHALL be checked after consume.
REQ-024 Macro PULSE_STRETCH_QUEUE_EN undefined: no pending register; Event in ON/OFF SHALL be discarded with Dropped, except REQ-017 still applies.

Structure
REQ-025 Shared package pulse_stretch_pkg SHALL hold the state encoding (IDLE=2'd0, ON=2'd1, OFF=2'd2) and width helper functions.
REQ-026 The interval down-counter SHALL be a sub-module cycle_timer (load value, load strobe, done flag).

Verification (ON_CYCLES=4, OFF_CYCLES=3, QUEUE_DEPTH=2)
REQ-027 Single Event at cycle 0 -> Output high cycles 1-4, low 5-7, Busy high 1-7, IDLE at cycle 8, Dropped never.
REQ-028 QUEUE_EN: Events at cycles 0,2,3,4 -> three high intervals starting 1, 8, 15; Dropped pulse at cycle 5 only.
REQ-029 QUEUE_EN: Event at cycle 7 (last OFF cycle) and no other pending -> second ON starts cycle 8, pending 0 at cycle 8.
REQ-030 No QUEUE_EN: Events at cycles 0 and 3 -> single interval 1-4, Dropped at cycle 4.
REQ-031 Rst_n low at cycle 3 with 2 pending -> Output 0 same cycle; after release no Output activity without new Event.
